// File: rtl/ultrasonic_echo_responder.sv
// ultrasonic_echo_responder: HC-SR04 sensor-side model answering a trig pulse with a programmed echo pulse
module ultrasonic_echo_responder #(
  parameter int TRIG_MIN_CYC  = 500,
  parameter int BURST_DLY_CYC = 10000,
  parameter int ECHO_W        = 22,
  parameter int TIMEOUT_CYC   = 1900000,
  parameter int HOLDOFF_CYC   = 3000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [ECHO_W-1:0] echo_width,
  input  logic              no_object,
  output logic              echo,
  output logic              busy,
  output logic              done,
  output logic              trig_short
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TRIG_HI = 3'd1;
  localparam logic [2:0] BURST   = 3'd2;
  localparam logic [2:0] ECHO    = 3'd3;
  localparam logic [2:0] HOLDOFF = 3'd4;
  localparam int C0 = $clog2(HOLDOFF_CYC + 1);
  localparam int C1 = $clog2(BURST_DLY_CYC + 1);
  localparam int C2 = $clog2(TRIG_MIN_CYC + 1);
  localparam int CA = C0 > C1 ? C0 : C1;
  localparam int CB = C2 > ECHO_W ? C2 : ECHO_W;
  localparam int CW = CA > CB ? CA : CB;
  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [ECHO_W-1:0] w_eff;
  logic [ECHO_W-1:0] w_next;
  logic              trig_m;
  logic              trig_s;
  logic              trig_s_d;
  logic              rise;
  logic              fall;
  // two-flop synchroniser plus edge-detect delay for the asynchronous trig
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      trig_s_d <= 1'b0;
    end else begin
      trig_m   <= trig;
      trig_s   <= trig_m;
      trig_s_d <= trig_s;
    end
  end
  // edge detection and clamped echo width captured at the valid trig fall
  always_comb begin
    rise   = trig_s & ~trig_s_d;
    fall   = ~trig_s & trig_s_d;
    w_next = (no_object || echo_width > ECHO_W'(TIMEOUT_CYC)) ? ECHO_W'(TIMEOUT_CYC) : echo_width;
    busy   = (state == BURST) || (state == ECHO) || (state == HOLDOFF);
  end
  // measurement sequencer: one shared counter times trig, burst, echo and holdoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      w_eff      <= '0;
      echo       <= 1'b0;
      done       <= 1'b0;
      trig_short <= 1'b0;
    end else begin
      done       <= 1'b0;
      trig_short <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= TRIG_HI;
            cnt   <= CW'(1);
          end
        end
        TRIG_HI: begin
          if (fall) begin
            if (cnt >= CW'(TRIG_MIN_CYC)) begin
              w_eff <= w_next;
              cnt   <= '0;
              state <= BURST;
            end else begin
              trig_short <= 1'b1;
              state      <= IDLE;
            end
          end else if (trig_s && cnt < CW'(TRIG_MIN_CYC)) begin
            cnt <= cnt + CW'(1);
          end
        end
        BURST: begin
          if (cnt == CW'(BURST_DLY_CYC - 1)) begin
            cnt <= '0;
            if (w_eff == '0) begin
              done  <= 1'b1;
              state <= HOLDOFF;
            end else begin
              echo  <= 1'b1;
              state <= ECHO;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ECHO: begin
          if (cnt + CW'(1) == CW'(w_eff)) begin
            echo  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= HOLDOFF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLDOFF: begin
          if (cnt == CW'(HOLDOFF_CYC - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// tb_ultrasonic_echo_responder: randomized check of echo timing against arithmetic expectations
module tb_ultrasonic_echo_responder;
  localparam int TMIN = 10;
  localparam int D    = 20;
  localparam int TO   = 1000;
  localparam int H    = 50;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [11:0] echo_width = '0;
  logic        no_object = 1'b0;
  logic        echo;
  logic        busy;
  logic        done;
  logic        trig_short;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rise, n_high, n_busy, n_done, n_short, t_rise, t_done, t_short;
  logic echo_q = 1'b0;
  ultrasonic_echo_responder #(
    .TRIG_MIN_CYC(TMIN), .BURST_DLY_CYC(D), .ECHO_W(12), .TIMEOUT_CYC(TO), .HOLDOFF_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .echo_width(echo_width), .no_object(no_object),
    .echo(echo), .busy(busy), .done(done), .trig_short(trig_short)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (echo && !echo_q) begin
      n_rise++;
      t_rise = cyc;
    end
    echo_q = echo;
    n_high += int'(echo);
    n_busy += int'(busy);
    if (done) begin
      n_done++;
      t_done = cyc;
    end
    if (trig_short) begin
      n_short++;
      t_short = cyc;
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_rise = 0; n_high = 0; n_busy = 0; n_done = 0; n_short = 0;
    t_rise = -1; t_done = -1; t_short = -1;
  endtask
  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic pulse(input int n, output int c);
    trig = 1'b1;
    wait_cyc(n);
    trig = 1'b0;
    c = cyc;
  endtask
  task automatic measure(input int n, input int w, input bit no);
    int c, we;
    @(negedge clk);
    echo_width = 12'(w);
    no_object = no;
    clr();
    pulse(n, c);
    if (n >= TMIN) begin
      we = (no || w > TO) ? TO : w;
      wait_cyc(6);
      echo_width = 12'($urandom_range(0, 4095));
      no_object = 1'($urandom_range(0, 1));
      wait_cyc(D + we + H + 10);
      chk("echo_rises", n_rise, we > 0 ? 1 : 0);
      if (we > 0) chk("echo_rise_cyc", t_rise, c + 3 + D);
      chk("echo_width", n_high, we);
      chk("done_count", n_done, 1);
      chk("done_cyc", t_done, c + 3 + D + we);
      chk("busy_cycles", n_busy, D + we + H);
      chk("no_short", n_short, 0);
    end else begin
      wait_cyc(20);
      chk("short_count", n_short, 1);
      chk("short_cyc", t_short, c + 3);
      chk("short_no_echo", n_rise, 0);
      chk("short_no_busy", n_busy, 0);
      chk("short_no_done", n_done, 0);
    end
  endtask
  initial begin
    int c, c2, n, w;
    bit no;
    wait_cyc(3);
    chk("rst_echo", echo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", trig_short, 0);
    rst_n = 1'b1;
    wait_cyc(3);
    measure(12, 300, 0);
    measure(5, 300, 0);
    measure(12, 300, 0);
    measure(12, 300, 1);
    measure(12, 2000, 0);
    measure(12, 0, 0);
    measure(10, 123, 0);
    measure(9, 123, 0);
    measure(12, 1000, 0);
    measure(12, 1001, 0);
    measure(12, 1, 0);
    @(negedge clk);
    echo_width = 12'd300;
    no_object = 1'b0;
    clr();
    pulse(12, c);
    wait_cyc(D + 100);
    pulse(12, c2);
    wait_cyc(c + 3 + D + 300 + 5 - cyc);
    trig = 1'b1;
    wait_cyc(H + 30);
    chk("lock_rises", n_rise, 1);
    chk("lock_width", n_high, 300);
    chk("lock_done", n_done, 1);
    chk("lock_short", n_short, 0);
    chk("lock_busy", n_busy, D + 300 + H);
    chk("lock_idle", busy, 0);
    trig = 1'b0;
    wait_cyc(10);
    chk("held_no_short", n_short, 0);
    chk("held_no_busy", n_busy, D + 300 + H);
    measure(12, 77, 0);
    @(negedge clk);
    echo_width = 12'd300;
    clr();
    pulse(12, c);
    wait_cyc(D + 50);
    chk("pre_rst_echo", echo, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_echo", echo, 0);
    chk("async_rst_busy", busy, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    measure(12, 200, 0);
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(5, 15);
      case ($urandom_range(0, 5))
        0: w = 0;
        1: w = $urandom_range(1001, 4095);
        default: w = $urandom_range(1, 400);
      endcase
      no = ($urandom_range(0, 3) == 0);
      measure(n, w, no);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
